// File: rtl/pmbus_arb_pkg.sv
// Shared states and constants for the PMBus command/CSR arbiter.
package pmbus_arb_pkg;

    localparam int unsigned ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT0,
        ST_GRANT1,
        ST_DONE
    } t_arb_states;

    localparam logic ARB_M0 = 1'b0;
    localparam logic ARB_M1 = 1'b1;

    // Byte returned to a master whose transfer was forcibly terminated
    localparam logic [7:0] PMB_NODATA_BYTE = 8'hFF;

endpackage

// File: rtl/pmbus_arb_timer.sv
// Stuck-slave watchdog: counts stalled grant cycles, flags when the limit is hit.
module pmbus_arb_timer #(
    parameter int unsigned TIMEOUT_CLKS = 255
) (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic CLEAR,
    input  logic RUN,
    output logic EXPIRED
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CLKS);

    logic [CNT_W-1:0] count;

    // Saturating stall counter, held at zero outside a grant
    always_ff @(posedge CLOCK) begin
        if (!RESET_N || CLEAR) begin
            count <= '0;
        end else if (RUN && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign EXPIRED = (count == CNT_MAX);

endmodule

// File: rtl/pmbus_cmd_arbiter.sv
// Round-robin arbiter between the PMBus bridge (M0) and a host CSR master (M1).
// Define PMBUS_ARB_TIMEOUT_EN to enable the stuck-slave timeout.
module pmbus_cmd_arbiter
    import pmbus_arb_pkg::*;
#(
    parameter int unsigned MAX_BYTES    = 2,
    parameter int unsigned TIMEOUT_CLKS = 255
) (
    input  logic                   CLOCK,
    input  logic                   RESET_N,
    input  logic [ADDR_W-1:0]      M0_COMMAND,
    input  logic [MAX_BYTES-1:0]   M0_BYTEEN,
    input  logic                   M0_READ,
    input  logic                   M0_WRITE,
    input  logic [MAX_BYTES*8-1:0] M0_WRITEDATA,
    output logic [MAX_BYTES*8-1:0] M0_READDATA,
    output logic                   M0_WAITREQUEST,
    input  logic [ADDR_W-1:0]      M1_ADDRESS,
    input  logic [MAX_BYTES-1:0]   M1_BYTEEN,
    input  logic                   M1_READ,
    input  logic                   M1_WRITE,
    input  logic [MAX_BYTES*8-1:0] M1_WRITEDATA,
    output logic [MAX_BYTES*8-1:0] M1_READDATA,
    output logic                   M1_WAITREQUEST,
    output logic [ADDR_W-1:0]      S_ADDRESS,
    output logic [MAX_BYTES-1:0]   S_BYTEEN,
    output logic                   S_READ,
    output logic                   S_WRITE,
    output logic [MAX_BYTES*8-1:0] S_WRITEDATA,
    input  logic                   S_WAITREQUEST,
    input  logic [MAX_BYTES*8-1:0] S_READDATA,
    output logic                   TIMEOUT
);
    localparam int unsigned DATA_W = MAX_BYTES * 8;

    t_arb_states          state, state_nxt;
    logic                 last_grant, last_grant_nxt;
    logic                 load, sel_nxt;
    logic                 mux_rd, mux_wr;
    logic [ADDR_W-1:0]    mux_addr;
    logic [MAX_BYTES-1:0] mux_be;
    logic [DATA_W-1:0]    mux_wd;
    logic                 req0, req1;
    logic                 in_grant, cur_sel, cur_req;
    logic                 timer_expired, timeout_hit;

    assign req0        = M0_READ | M0_WRITE;
    assign req1        = M1_READ | M1_WRITE;
    assign in_grant    = (state == ST_GRANT0) || (state == ST_GRANT1);
    assign cur_sel     = (state == ST_GRANT1) ? ARB_M1 : ARB_M0;
    assign cur_req     = (cur_sel == ARB_M1) ? req1 : req0;
    assign timeout_hit = in_grant && timer_expired && S_WAITREQUEST;

`ifdef PMBUS_ARB_TIMEOUT_EN
    pmbus_arb_timer #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timer (
        .CLOCK  (CLOCK),
        .RESET_N(RESET_N),
        .CLEAR  (!in_grant),
        .RUN    (in_grant && S_WAITREQUEST),
        .EXPIRED(timer_expired)
    );
`else
    assign timer_expired = 1'b0;
`endif

    // Arbitration, grant tracking and selection of the master feeding the slave port
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        sel_nxt        = ARB_M0;
        load           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req0 && (!req1 || (last_grant == ARB_M1))) begin
                    state_nxt = ST_GRANT0;
                    sel_nxt   = ARB_M0;
                    load      = 1'b1;
                end else if (req1) begin
                    state_nxt = ST_GRANT1;
                    sel_nxt   = ARB_M1;
                    load      = 1'b1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                sel_nxt = cur_sel;
                if (!S_WAITREQUEST || timeout_hit) begin
                    state_nxt      = ST_DONE;
                    last_grant_nxt = cur_sel;
                end else if (!cur_req) begin
                    state_nxt = ST_IDLE;
                end else begin
                    load = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        if (sel_nxt == ARB_M1) begin
            mux_rd   = M1_READ;
            mux_wr   = M1_WRITE;
            mux_addr = M1_ADDRESS;
            mux_be   = M1_BYTEEN;
            mux_wd   = M1_WRITEDATA;
        end else begin
            mux_rd   = M0_READ;
            mux_wr   = M0_WRITE;
            mux_addr = M0_COMMAND;
            mux_be   = M0_BYTEEN;
            mux_wd   = M0_WRITEDATA;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            last_grant  <= ARB_M1;
            S_READ      <= 1'b0;
            S_WRITE     <= 1'b0;
            S_ADDRESS   <= '0;
            S_BYTEEN    <= '0;
            S_WRITEDATA <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            // A write always wins over a simultaneous read
            S_WRITE    <= load && mux_wr;
            S_READ     <= load && mux_rd && !mux_wr;
            if (load) begin
                S_ADDRESS   <= mux_addr;
                S_BYTEEN    <= mux_be;
                S_WRITEDATA <= mux_wd;
            end
        end
    end

    // Handshake return path to the granted master
    always_comb begin
        M0_WAITREQUEST = 1'b1;
        M1_WAITREQUEST = 1'b1;
        M0_READDATA    = '0;
        M1_READDATA    = '0;
        TIMEOUT        = 1'b0;
        if (in_grant) begin
            if (cur_sel == ARB_M1) begin
                M1_WAITREQUEST = S_WAITREQUEST && !timeout_hit;
                M1_READDATA    = timeout_hit ? {MAX_BYTES{PMB_NODATA_BYTE}} : S_READDATA;
            end else begin
                M0_WAITREQUEST = S_WAITREQUEST && !timeout_hit;
                M0_READDATA    = timeout_hit ? {MAX_BYTES{PMB_NODATA_BYTE}} : S_READDATA;
            end
            TIMEOUT = timeout_hit;
        end
    end

endmodule

// File: tb/tb_pmbus_cmd_arbiter.sv
// Directed and randomized checks of pmbus_cmd_arbiter against a transaction-level model.
module tb_pmbus_cmd_arbiter;
    localparam int unsigned MAX_BYTES    = 2;
    localparam int unsigned TIMEOUT_CLKS = 15;
    localparam int unsigned DW           = MAX_BYTES * 8;

    typedef struct packed {
        logic          wr;
        logic [7:0]    addr;
        logic [1:0]    be;
        logic [DW-1:0] wd;
    } txn_t;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    m0_command, m1_address, s_address;
    logic [1:0]    m0_byteen, m1_byteen, s_byteen;
    logic          m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
    logic          m0_waitrequest, m1_waitrequest, s_waitrequest, timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pmbus_cmd_arbiter #(
        .MAX_BYTES   (MAX_BYTES),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .CLOCK         (clock),
        .RESET_N       (reset_n),
        .M0_COMMAND    (m0_command),
        .M0_BYTEEN     (m0_byteen),
        .M0_READ       (m0_read),
        .M0_WRITE      (m0_write),
        .M0_WRITEDATA  (m0_writedata),
        .M0_READDATA   (m0_readdata),
        .M0_WAITREQUEST(m0_waitrequest),
        .M1_ADDRESS    (m1_address),
        .M1_BYTEEN     (m1_byteen),
        .M1_READ       (m1_read),
        .M1_WRITE      (m1_write),
        .M1_WRITEDATA  (m1_writedata),
        .M1_READDATA   (m1_readdata),
        .M1_WAITREQUEST(m1_waitrequest),
        .S_ADDRESS     (s_address),
        .S_BYTEEN      (s_byteen),
        .S_READ        (s_read),
        .S_WRITE       (s_write),
        .S_WRITEDATA   (s_writedata),
        .S_WAITREQUEST (s_waitrequest),
        .S_READDATA    (s_readdata),
        .TIMEOUT       (timeout)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_masters();
        m0_read = 1'b0; m0_write = 1'b0; m0_command = '0; m0_byteen = '0; m0_writedata = '0;
        m1_read = 1'b0; m1_write = 1'b0; m1_address = '0; m1_byteen = '0; m1_writedata = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_masters();
        s_waitrequest = 1'b1;
        s_readdata = '0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    function automatic txn_t mk_txn(input logic m);
        txn_t t;
        t.wr   = 1'($urandom_range(0, 1));
        t.addr = {m, 7'($urandom)};
        t.be   = 2'($urandom_range(1, 3));
        t.wd   = DW'($urandom);
        return t;
    endfunction

    // Random-phase model state
    txn_t       q0[$], q1[$];
    logic       act0, act1, prev_strobe, last_other_req;
    int         gap0, gap1, wait_left, last_m, done_cnt;
    logic [DW-1:0] rdata_cur;

    task automatic drive_masters();
        txn_t t0, t1;
        t0 = (q0.size() > 0) ? q0[0] : '0;
        t1 = (q1.size() > 0) ? q1[0] : '0;
        m0_read = act0 && !t0.wr; m0_write = act0 && t0.wr;
        m0_command = t0.addr; m0_byteen = t0.be; m0_writedata = t0.wd;
        m1_read = act1 && !t1.wr; m1_write = act1 && t1.wr;
        m1_address = t1.addr; m1_byteen = t1.be; m1_writedata = t1.wd;
    endtask

    task automatic score_done(input int m, input txn_t t);
        check_val("rnd_strobe", t.wr ? s_write : s_read, 1);
        check_val("rnd_addr", s_address, t.addr);
        check_val("rnd_byteen", s_byteen, t.be);
        if (t.wr) check_val("rnd_wdata", s_writedata, t.wd);
        else      check_val("rnd_rdata", (m == 1) ? m1_readdata : m0_readdata, rdata_cur);
        if (last_m >= 0 && last_other_req) check_val("rnd_fair", m, 1 - last_m);
        last_m = m;
        last_other_req = (m == 1) ? act0 : act1;
        done_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int order[$];
        int when[$];
        int ack_cnt, wr_cnt;
        logic d0, d1;
        txn_t h0, h1;

        // Reset state
        do_reset();
        check_val("rst_s_read", s_read, 0);
        check_val("rst_s_write", s_write, 0);
        check_val("rst_s_address", s_address, 0);
        check_val("rst_s_writedata", s_writedata, 0);
        check_val("rst_m0_wait", m0_waitrequest, 1);
        check_val("rst_m1_wait", m1_waitrequest, 1);
        check_val("rst_m0_rdata", m0_readdata, 0);
        check_val("rst_timeout", timeout, 0);

        // 1: M0 read of 8'h8B, slave stalls 3 cycles
        m0_command = 8'h8B; m0_byteen = 2'b11; m0_read = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            s_waitrequest = (k < 4);
            s_readdata = (k == 4) ? 16'h1234 : 16'h0000;
            #1;
            check_val("t1_s_read", s_read, 1);
            check_val("t1_s_address", s_address, 8'h8B);
            check_val("t1_m1_wait", m1_waitrequest, 1);
            check_val("t1_m0_wait", m0_waitrequest, (k < 4) ? 1 : 0);
        end
        check_val("t1_m0_rdata", m0_readdata, 16'h1234);
        m0_read = 1'b0;
        s_waitrequest = 1'b1;
        tick();
        check_val("t1_done_s_read", s_read, 0);
        check_val("t1_done_m0_wait", m0_waitrequest, 1);

        // 2: simultaneous held writes alternate starting with M0
        do_reset();
        m0_command = 8'h10; m0_writedata = 16'h0B0B; m0_byteen = 2'b11; m0_write = 1'b1;
        m1_address = 8'h20; m1_writedata = 16'h1C1C; m1_byteen = 2'b11; m1_write = 1'b1;
        s_waitrequest = 1'b0;
        for (int cyc = 0; cyc < 40 && order.size() < 4; cyc++) begin
            tick();
            if (!m0_waitrequest) begin
                order.push_back(0); when.push_back(cyc);
                check_val("t2_addr0", s_address, 8'h10);
            end
            if (!m1_waitrequest) begin
                order.push_back(1); when.push_back(cyc);
                check_val("t2_addr1", s_address, 8'h20);
            end
        end
        check_val("t2_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) check_val("t2_order", order[i], i % 2);
        for (int i = 1; i < when.size(); i++) check_val("t2_spacing", when[i] - when[i-1], 3);
        idle_masters();
        s_waitrequest = 1'b1;
        repeat (3) tick();

        // 3: M1 write to a zero-wait slave
        m1_address = 8'h21; m1_writedata = 16'hA5A5; m1_byteen = 2'b01; m1_write = 1'b1;
        s_waitrequest = 1'b0;
        ack_cnt = 0; wr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) begin
                check_val("t3_s_write", s_write, 1);
                check_val("t3_s_read", s_read, 0);
                check_val("t3_s_address", s_address, 8'h21);
                check_val("t3_s_wdata", s_writedata, 16'hA5A5);
                check_val("t3_s_byteen", s_byteen, 2'b01);
                check_val("t3_m0_wait", m0_waitrequest, 1);
            end
            if (s_write) wr_cnt++;
            if (!m1_waitrequest) begin
                ack_cnt++;
                m1_write = 1'b0;
            end
        end
        check_val("t3_ack_cycles", ack_cnt, 1);
        check_val("t3_write_cycles", wr_cnt, 1);

        // Read and write raised together: the write wins
        m0_command = 8'h77; m0_writedata = 16'hBEEF; m0_byteen = 2'b11;
        m0_read = 1'b1; m0_write = 1'b1;
        tick();
        check_val("rw_s_write", s_write, 1);
        check_val("rw_s_read", s_read, 0);
        check_val("rw_s_wdata", s_writedata, 16'hBEEF);
        idle_masters();
        s_waitrequest = 1'b1;
        repeat (3) tick();

`ifdef PMBUS_ARB_TIMEOUT_EN
        // 4: slave never answers
        do_reset();
        m0_command = 8'h99; m0_read = 1'b1;
        tick();
        for (int c = 0; c < 15; c++) begin
            check_val("t4_no_timeout", timeout, 0);
            check_val("t4_m0_wait", m0_waitrequest, 1);
            tick();
        end
        check_val("t4_timeout", timeout, 1);
        check_val("t4_m0_wait_rel", m0_waitrequest, 0);
        check_val("t4_m0_rdata", m0_readdata, 16'hFFFF);
        check_val("t4_m1_wait", m1_waitrequest, 1);
        m0_read = 1'b0;
        m1_address = 8'hC3; m1_read = 1'b1;
        tick();
        check_val("t4_pulse_end", timeout, 0);
        check_val("t4_done_s_read", s_read, 0);
        tick();
        check_val("t4_idle_s_read", s_read, 0);
        tick();
        check_val("t4_regrant", s_read, 1);
        check_val("t4_regrant_addr", s_address, 8'hC3);
        idle_masters();
        s_waitrequest = 1'b0;
        tick();
        s_waitrequest = 1'b1;
        repeat (3) tick();
`endif

        // 5: reset in the middle of an M1 grant
        m1_address = 8'h44; m1_read = 1'b1;
        s_waitrequest = 1'b1;
        tick();
        check_val("t5_granted", s_address, 8'h44);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m0_command = 8'h33; m0_read = 1'b1;
        #1;
        check_val("t5_s_read", s_read, 0);
        check_val("t5_s_write", s_write, 0);
        check_val("t5_m0_wait", m0_waitrequest, 1);
        check_val("t5_m1_wait", m1_waitrequest, 1);
        tick();
        check_val("t5_tie_addr", s_address, 8'h33);
        s_waitrequest = 1'b0;
        #1;
        check_val("t5_tie_m0_ack", m0_waitrequest, 0);
        check_val("t5_tie_m1_wait", m1_waitrequest, 1);
        idle_masters();
        tick();
        s_waitrequest = 1'b1;
        repeat (3) tick();

        // 6: M0 abandons its read while the slave stalls
        do_reset();
        m0_command = 8'h55; m0_read = 1'b1;
        tick();
        check_val("t6_s_read", s_read, 1);
        tick();
        m0_read = 1'b0;
        tick();
        check_val("t6_dropped", s_read, 0);
        check_val("t6_no_ack", m0_waitrequest, 1);
        m0_command = 8'h56; m0_read = 1'b1;
        m1_address = 8'h66; m1_read = 1'b1;
        tick();
        check_val("t6_tie_addr", s_address, 8'h56);
        s_waitrequest = 1'b0;
        #1;
        check_val("t6_tie_m0_ack", m0_waitrequest, 0);
        idle_masters();
        tick();
        s_waitrequest = 1'b1;
        repeat (3) tick();

        // Randomized traffic from both masters against a transaction-level model
        do_reset();
        for (int i = 0; i < 24; i++) begin
            q0.push_back(mk_txn(1'b0));
            q1.push_back(mk_txn(1'b1));
        end
        act0 = 1'b1; act1 = 1'b1; gap0 = 0; gap1 = 0;
        wait_left = 0; prev_strobe = 1'b0; rdata_cur = '0;
        last_m = -1; last_other_req = 1'b0; done_cnt = 0;
        drive_masters();
        for (int cyc = 0; cyc < 3000 && (q0.size() != 0 || q1.size() != 0); cyc++) begin
            tick();
            if (s_read || s_write) begin
                if (!prev_strobe) begin
                    wait_left = $urandom_range(0, 3);
                    rdata_cur = DW'($urandom);
                end
                s_waitrequest = (wait_left > 0);
                if (wait_left > 0) wait_left--;
            end else begin
                s_waitrequest = 1'b1;
            end
            s_readdata = rdata_cur;
            prev_strobe = s_read || s_write;
            #1;
            if (timeout) check_val("rnd_timeout", timeout, 0);
            d0 = act0 && !m0_waitrequest;
            d1 = act1 && !m1_waitrequest;
            h0 = (q0.size() > 0) ? q0[0] : '0;
            h1 = (q1.size() > 0) ? q1[0] : '0;
            if (d0) score_done(0, h0);
            if (d1) score_done(1, h1);
            if (d0) begin void'(q0.pop_front()); act0 = 1'b0; gap0 = $urandom_range(0, 2); end
            if (d1) begin void'(q1.pop_front()); act1 = 1'b0; gap1 = $urandom_range(0, 2); end
            if (!act0 && q0.size() > 0) begin if (gap0 > 0) gap0--; else act0 = 1'b1; end
            if (!act1 && q1.size() > 0) begin if (gap1 > 0) gap1--; else act1 = 1'b1; end
            drive_masters();
        end
        check_val("rnd_q0_drained", q0.size(), 0);
        check_val("rnd_q1_drained", q1.size(), 0);
        check_val("rnd_completions", done_cnt, 48);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
